// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA output path.
//
// Counts pixels (h_cnt) and lines (v_cnt) on a pixel clock-enable and produces registered
// sync/data-enable/strobe decodes that are aligned with the x/y coordinates they describe.
// Also counts completed frames.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   pix_ce       pixel clock-enable, one pixel advance per clk while high
//   hsync/vsync  sync outputs, active level set by H_POL / V_POL
//   de           high inside the visible area
//   x / y        horizontal / vertical counters
//   line_start   high while h_cnt == 0
//   frame_start  high while h_cnt == 0 and v_cnt == 0
//   frame_cnt    completed-frame count, wraps modulo 2^FRAME_W
//
// Build option: define VGA_TIMING_PIPE_EN to delay every output except frame_cnt by
// PIPE_DELAY pixel-enable edges, matching a PIPE_DELAY-deep downstream pixel pipeline.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned FRAME_W    = 8,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

`ifdef VGA_TIMING_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    localparam int unsigned STAGES  = PIPE_EN ? PIPE_DELAY : 0;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned OUT_W = 2 * CNT_W + 5;

    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    logic [OUT_W-1:0]   out_now;
    logic [OUT_W-1:0]   out_del;

    // Decodes are taken from the next counter values so the registered flags line up with
    // the registered coordinates (no lag between x/y and the sync/de they describe).
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d     = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end

        hsync_d       = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? H_POL : ~H_POL;
        vsync_d       = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? V_POL : ~V_POL;
        de_d          = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
        line_start_d  = (h_cnt_d == '0);
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out_now = {h_cnt_q, v_cnt_q, hsync_q, vsync_q, de_q, line_start_q, frame_start_q};

    if (STAGES == 0) begin : g_no_pipe
        assign out_del = out_now;
    end else begin : g_pipe
        localparam logic [OUT_W-1:0] OUT_RST = {{CNT_W{1'b0}}, {CNT_W{1'b0}}, ~H_POL, ~V_POL,
                                                1'b1, 1'b1, 1'b1};

        logic [OUT_W-1:0] pipe_q [STAGES];
        logic [OUT_W-1:0] pipe_d [STAGES];

        // Shift only on pixel enables so the delay is measured in pixels, not clocks.
        always_comb begin
            pipe_d = pipe_q;
            if (pix_ce) begin
                pipe_d[0] = out_now;
                for (int i = 1; i < STAGES; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < STAGES; i++) begin
                    pipe_q[i] <= OUT_RST;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign out_del = pipe_q[STAGES-1];
    end

    assign {x, y, hsync, vsync, de, line_start, frame_start} = out_del;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances driven from shared rst/pix_ce.
//   dut_a: default 640x480 timing, active-low syncs, 8-bit frame counter.
//   dut_b: small 32x17 raster, active-high syncs, 3-bit frame counter (wraps quickly).
// Expected outputs come from a pixel-index model: after n pixel enables since reset,
// h = n mod H_TOTAL, v = (n div H_TOTAL) mod V_TOTAL, frames = n div (H_TOTAL*V_TOTAL).
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
    localparam longint PD = 2;
`else
    localparam longint PD = 0;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pix_ce;

    logic       a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic [2:0] b_fc;

    int         checks = 0;
    int         errors = 0;
    longint     n = 0;

    vga_timing_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .de          (a_de),
        .x           (a_x),
        .y           (a_y),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .frame_cnt   (a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (6),
        .V_ACTIVE (10),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .H_POL    (1'b1),
        .V_POL    (1'b1),
        .FRAME_W  (3)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .de          (b_de),
        .x           (b_x),
        .y           (b_y),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .frame_cnt   (b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input longint p, input longint ha, input longint hf,
                                   input longint hsw, input longint hb, input longint va,
                                   input longint vf, input longint vsw, input longint vb,
                                   input bit hp, input bit vp);
        exp_t   e;
        longint ht, vt, h, v;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        h    = p % ht;
        v    = (p / ht) % vt;
        e.x  = 10'(h);
        e.y  = 10'(v);
        e.de = (h < ha) && (v < va);
        e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d at pixel %0d", tag, got, want, n);
        end
    endtask

    task automatic check_all();
        exp_t   ea, eb;
        longint nd;
        nd = (n > PD) ? n - PD : 0;
        ea = model(nd, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        eb = model(nd, 16, 4, 6, 6, 10, 2, 2, 3, 1'b1, 1'b1);
        chk("a_x",  32'(a_x),  32'(ea.x));
        chk("a_y",  32'(a_y),  32'(ea.y));
        chk("a_hs", 32'(a_hs), 32'(ea.hs));
        chk("a_vs", 32'(a_vs), 32'(ea.vs));
        chk("a_de", 32'(a_de), 32'(ea.de));
        chk("a_ls", 32'(a_ls), 32'(ea.ls));
        chk("a_fs", 32'(a_fs), 32'(ea.fs));
        chk("a_fc", 32'(a_fc), 32'((n / 420000) % 256));
        chk("b_x",  32'(b_x),  32'(eb.x));
        chk("b_y",  32'(b_y),  32'(eb.y));
        chk("b_hs", 32'(b_hs), 32'(eb.hs));
        chk("b_vs", 32'(b_vs), 32'(eb.vs));
        chk("b_de", 32'(b_de), 32'(eb.de));
        chk("b_ls", 32'(b_ls), 32'(eb.ls));
        chk("b_fs", 32'(b_fs), 32'(eb.fs));
        chk("b_fc", 32'(b_fc), 32'((n / 544) % 8));
    endtask

    // Apply inputs just after an edge, take the next edge, then compare 1 time unit later.
    task automatic step(input logic r, input logic ce);
        rst    = r;
        pix_ce = ce;
        @(posedge clk);
        if (r) n = 0;
        else if (ce) n = n + 1;
        #1;
        check_all();
    endtask

    initial begin
        int stop_at;
        rst    = 1'b1;
        pix_ce = 1'b1;

        // Reset with pix_ce high: counters must not advance.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // One and a bit lines at full rate (de fall, hsync window, x wrap on the 640 raster).
        for (int i = 0; i < 900; i++) step(1'b0, 1'b1);

        // Strict alternation of pix_ce: outputs must hold on the idle cycles.
        for (int i = 0; i < 40; i++) step(1'b0, 1'(i % 2 == 0));

        // Randomly duty-cycled enable; long enough for the small raster's frame counter to wrap.
        for (int i = 0; i < 7000; i++) step(1'b0, 1'($urandom_range(0, 3) != 0));

        // Reset mid-frame at a random point, then resume.
        stop_at = int'($urandom_range(50, 400));
        for (int i = 0; i < stop_at; i++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);
        for (int i = 0; i < 1200; i++) step(1'b0, 1'($urandom_range(0, 4) != 0));

        // Reset held while pix_ce toggles, then a final full-rate burst.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
